// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
`timescale 1ns/1ps
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      divop,
   input  logic [XLEN-1:0] opr_a,
   input  logic [XLEN-1:0] opr_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] div_res,
   output logic [1:0]      dbg_state_o
);

   localparam int CNT_W = $clog2(XLEN);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   logic [1:0]      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // The partial remainder is always below the divisor after a step, so its
   // 33rd bit is constant zero and only exists transiently inside the trial value.
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            rem_sel_q, rem_sel_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   logic [XLEN-1:0] res_q, res_d;

   logic            signed_op;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            sgn_ovf;
   logic [XLEN-1:0] spec_res;

   logic [XLEN:0]   trial;
   logic            trial_ge;
   logic [XLEN-1:0] rem_step;
   logic [XLEN-1:0] quo_step;
   logic [XLEN-1:0] quo_fin;
   logic [XLEN-1:0] rem_fin;
   logic            last_step;

   // Operand preparation for a launch in IDLE.
   always_comb begin
      signed_op = ~divop[0];
      a_neg     = signed_op & opr_a[XLEN-1];
      b_neg     = signed_op & opr_b[XLEN-1];
      a_mag     = a_neg ? (~opr_a + 1'b1) : opr_a;
      b_mag     = b_neg ? (~opr_b + 1'b1) : opr_b;
      div_zero  = (opr_b == '0);
      sgn_ovf   = signed_op && (opr_a == MIN_NEG) && (opr_b == ALL_ONES);
      if (div_zero) begin
         spec_res = divop[1] ? opr_a : ALL_ONES;
      end else begin
         spec_res = divop[1] ? '0 : MIN_NEG;
      end
   end

   // One restoring step: shift the next dividend bit in and try to subtract.
   always_comb begin
      trial     = {rem_q, quo_q[XLEN-1]};
      trial_ge  = (trial >= {1'b0, dvs_q});
      if (trial_ge) begin
         rem_step = trial[XLEN-1:0] - dvs_q;
      end else begin
         rem_step = trial[XLEN-1:0];
      end
      quo_step  = {quo_q[XLEN-2:0], trial_ge};
      quo_fin   = q_neg_q ? (~quo_step + 1'b1) : quo_step;
      rem_fin   = r_neg_q ? (~rem_step + 1'b1) : rem_step;
      last_step = (cnt_q == CNT_W'(XLEN - 1));
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      rem_sel_d = rem_sel_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      res_d     = res_q;

      case (state_q)
         ST_IDLE: begin
            if (!flush && start) begin
               rem_sel_d = divop[1];
               q_neg_d   = a_neg ^ b_neg;
               r_neg_d   = a_neg;
               if (div_zero || sgn_ovf) begin
                  res_d   = spec_res;
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               rem_d = rem_step;
               quo_d = quo_step;
               cnt_d = cnt_q + 1'b1;
               if (last_step) begin
                  res_d   = rem_sel_q ? rem_fin : quo_fin;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         rem_sel_q <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         rem_sel_q <= rem_sel_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         res_q     <= res_d;
      end
   end

   // Handshake: busy is high in every non-IDLE state; done pulses for the single
   // DONE cycle and div_res is valid then and held until the next completion.
   // Both are pure state decodes, so start/flush never reach them combinationally.
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign div_res     = res_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed results, latency, interference, flush and reset.
`timescale 1ns/1ps
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  divop;
   logic [31:0] opr_a;
   logic [31:0] opr_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] div_res;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   div_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .divop       (divop),
      .opr_a       (opr_a),
      .opr_b       (opr_b),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .div_res     (div_res),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation and follow it to completion. With interfere set, start
   // stays high with scrambled operands for the whole flight, including DONE.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input bit interfere);
      int          lat;
      logic        busy_ok;
      logic [31:0] exp;
      exp_q.push_back(exp_res);
      divop = op;
      opr_a = a;
      opr_b = b;
      start = 1'b1;
      step();
      if (interfere) begin
         opr_a = ~a;
         opr_b = b ^ 32'h0000_0005;
         divop = ~op;
      end else begin
         start = 1'b0;
         opr_a = $urandom;
         opr_b = $urandom;
      end
      lat     = 1;
      busy_ok = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         step();
         lat++;
      end
      check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, " busy_in_flight"}, {31'b0, busy_ok & busy}, 32'd1);
      exp = exp_q.pop_front();
      check_eq({tag, " result"}, div_res, exp);
      last_res = exp;
      step();
      start = 1'b0;
      check_eq({tag, " done_cleared"}, {31'b0, done}, 32'd0);
      check_eq({tag, " idle_after"}, {31'b0, busy}, 32'd0);
   endtask

   int done_seen;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      divop = 2'b00;
      opr_a = '0;
      opr_b = '0;
      last_res = '0;
      #3;
      check_eq("reset busy", {31'b0, busy}, 32'd0);
      check_eq("reset done", {31'b0, done}, 32'd0);
      check_eq("reset div_res", div_res, 32'd0);
      check_eq("reset state", {30'b0, dbg_state}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step();

      // normal divisions, signed and unsigned
      run_op("divu_100_7",   OP_DIVU, 32'd100,       32'd7,         32'd14,        33, 1'b0);
      run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
      run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
      run_op("div_m100_7",   OP_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33, 1'b0);
      run_op("rem_m100_7",   OP_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33, 1'b0);
      run_op("div_100_m7",   OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b0);
      run_op("rem_100_m7",   OP_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,         33, 1'b0);
      run_op("divu_min_m1",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 1'b0);
      run_op("remu_min_m1",  OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
      run_op("remu_7_100",   OP_REMU, 32'd7,         32'd100,       32'd7,         33, 1'b0);
      run_op("div_0_5",      OP_DIV,  32'd0,         32'd5,         32'd0,         33, 1'b0);

      // early-exit special cases
      run_op("remu_5_0",     OP_REMU, 32'd5,         32'd0,         32'd5,         1,  1'b0);
      run_op("div_5_0",      OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0);
      run_op("rem_m5_0",     OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  1'b0);
      run_op("div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
      run_op("rem_ovf",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0);

      // start held high during flight must be ignored
      run_op("divu_intf",    OP_DIVU, 32'd1000,      32'd3,         32'd333,       33, 1'b1);
      run_op("divz_intf",    OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 1,  1'b1);

      // flush at T+10
      divop = OP_DIVU;
      opr_a = 32'd5000;
      opr_b = 32'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      check_eq("flush busy_before", {31'b0, busy}, 32'd1);
      step();
      flush = 1'b0;
      check_eq("flush idle", {30'b0, dbg_state}, 32'd0);
      done_seen = 0;
      repeat (40) begin
         if (done) done_seen++;
         step();
      end
      check_eq("flush no_done", 32'(done_seen), 32'd0);
      check_eq("flush res_held", div_res, last_res);

      // flush beats start in IDLE
      flush = 1'b1;
      start = 1'b1;
      step();
      flush = 1'b0;
      start = 1'b0;
      check_eq("flush_idle no_launch", {31'b0, busy}, 32'd0);

      // async reset mid-CALC at T+20
      divop = OP_DIVU;
      opr_a = 32'd123456;
      opr_b = 32'd11;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (19) step();
      check_eq("rst busy_before", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rst busy", {31'b0, busy}, 32'd0);
      check_eq("rst done", {31'b0, done}, 32'd0);
      check_eq("rst div_res", div_res, 32'd0);
      #2 rst_n = 1'b1;
      step();
      check_eq("rst stays_idle", {31'b0, busy}, 32'd0);
      run_op("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 1'b0);

      check_eq("scoreboard empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
